// File: rtl/mem_arbiter_nch.sv
// NUM_CH-channel arbiter onto a byte-serial RAM/IO bus (8-bit data, 1-cycle read latency).
// Define ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest channel wins).
module mem_arbiter_nch #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_BYTES = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     io_buffer_full,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*32-1:0]     ch_wdata,
    input  logic [NUM_CH*3-1:0]      ch_len,
    input  logic [NUM_CH-1:0]        ch_kill,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [31:0]              ch_rdata,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned K_W  = 3;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_TAIL, S_DONE} state_t;

    state_t              state, state_d;
    logic [K_W-1:0]      k, k_d, n_len, n_len_d, cap_idx, cap_idx_d;
    logic [CH_W-1:0]     gnt, gnt_d, gnt_sel;
    logic [ADDR_W-1:0]   base, base_d, addr_d, mem_a_d;
    logic                we_q, we_d, cap_valid, cap_valid_d, mem_wr_d;
    logic [31:0]         wdata_q, wdata_d, rbuf, rbuf_d, rdata_cap, ch_rdata_d;
    logic [7:0]          mem_dout_d;
    logic [NUM_CH-1:0]   ch_done_d;
    logic [K_W-1:0]      sel_len, sel_n;
    logic [5:0]          cap_sh;
    logic                req_any, grant, kill_hit, issued, last_k, busy_d;
    int unsigned         rr_idx;

`ifdef ARB_RR_EN
    logic [CH_W-1:0]     rr_ptr;
`endif

    // Winner selection: the last loop hit is the highest-priority requester.
    always_comb begin
        gnt_sel = '0;
        rr_idx  = 0;
        req_any = |ch_req;
`ifdef ARB_RR_EN
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            rr_idx = (32'(rr_ptr) + i - 1) % NUM_CH;
            if (ch_req[CH_W'(rr_idx)]) gnt_sel = CH_W'(rr_idx);
        end
`else
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (ch_req[CH_W'(i - 1)]) gnt_sel = CH_W'(i - 1);
        end
`endif
        sel_len = ch_len[gnt_sel*3 +: 3];
        if (sel_len == 3'd0)                   sel_n = 3'd1;
        else if (sel_len > K_W'(MAX_BYTES))    sel_n = K_W'(MAX_BYTES);
        else                                   sel_n = sel_len;
    end

    assign kill_hit = ch_kill[gnt] && !we_q;
    // A write byte counts as issued only if its strobe actually reached the bus.
    assign issued   = !we_q || mem_wr;
    assign last_k   = (k == n_len - 3'd1);
    assign grant    = rdy_in && (state == S_IDLE) && req_any;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= S_IDLE;
        else           state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (rdy_in) begin
            case (state)
                S_IDLE: if (req_any) state_d = S_XFER;
                S_XFER: begin
                    if (kill_hit)                state_d = S_IDLE;
                    else if (issued && last_k)   state_d = we_q ? S_DONE : S_TAIL;
                end
                S_TAIL:  state_d = kill_hit ? S_IDLE : S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        gnt_d   = grant ? gnt_sel : gnt;
        base_d  = grant ? ch_addr[gnt_sel*ADDR_W +: ADDR_W] : base;
        we_d    = grant ? ch_we[gnt_sel] : we_q;
        wdata_d = grant ? ch_wdata[gnt_sel*32 +: 32] : wdata_q;
        n_len_d = grant ? sel_n : n_len;

        k_d = k;
        if (grant)
            k_d = '0;
        else if (rdy_in && state == S_XFER && issued && !last_k)
            k_d = k + 3'd1;

        busy_d = (state_d == S_XFER) || (state_d == S_TAIL);
        addr_d = base_d + ADDR_W'(k_d);

        // Byte returned this cycle belongs to the index driven last cycle.
        cap_sh      = {cap_idx, 3'b000};
        rdata_cap   = (rbuf & ~(32'hFF << cap_sh)) | (32'(mem_din) << cap_sh);
        cap_valid_d = (state == S_XFER) || (state == S_TAIL);
        cap_idx_d   = k;
        rbuf_d      = rbuf;
        if (grant)
            rbuf_d = '0;
        else if (cap_valid && ((state == S_XFER) || (state == S_TAIL)))
            rbuf_d = rdata_cap;

        mem_a_d    = mem_a;
        mem_dout_d = mem_dout;
        mem_wr_d   = 1'b0;
        ch_done_d  = '0;
        ch_rdata_d = ch_rdata;
        if (rdy_in) begin
            mem_a_d    = busy_d ? addr_d : '0;
            mem_dout_d = (state_d == S_XFER && we_d) ? 8'(wdata_d >> {k_d, 3'b000}) : 8'd0;
            // IO-region write held off while the UART buffer is full.
            mem_wr_d   = (state_d == S_XFER) && we_d && !((addr_d[17:16] == 2'b11) && io_buffer_full);
            if (state_d == S_DONE && state != S_DONE) ch_done_d = NUM_CH'(1) << gnt_d;
            if (state == S_TAIL && state_d == S_DONE) ch_rdata_d = rdata_cap;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            k         <= '0;
            n_len     <= 3'd1;
            gnt       <= '0;
            base      <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rbuf      <= '0;
            cap_valid <= 1'b0;
            cap_idx   <= '0;
            mem_a     <= '0;
            mem_dout  <= '0;
            mem_wr    <= 1'b0;
            ch_done   <= '0;
            ch_rdata  <= '0;
        end else begin
            k         <= k_d;
            n_len     <= n_len_d;
            gnt       <= gnt_d;
            base      <= base_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            rbuf      <= rbuf_d;
            cap_valid <= cap_valid_d;
            cap_idx   <= cap_idx_d;
            mem_a     <= mem_a_d;
            mem_dout  <= mem_dout_d;
            mem_wr    <= mem_wr_d;
            ch_done   <= ch_done_d;
            ch_rdata  <= ch_rdata_d;
        end
    end

`ifdef ARB_RR_EN
    // Next search starts just past the channel granted last.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            rr_ptr <= '0;
        else if (grant)
            rr_ptr <= (gnt_sel == CH_W'(NUM_CH - 1)) ? '0 : gnt_sel + CH_W'(1);
    end
`endif

endmodule
